tile_renderer: RTL and testbench

Background tile stage that sits directly upstream of the 24x24 ground and platform tile ROMs. It turns raster coordinates plus a horizontal scroll offset into a tile-map lookup and a ROM address. It then selects the returned 12-bit pixel and emits pipeline-aligned RGB and syncs to the VGA output stage. clk is the pixel clock: one pixel per cycle.

---
 rtl/tile_renderer.sv | 210 +++++++++++++++++++++
 tb/tb_tile_renderer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/tile_renderer.sv
// Background tile stage: scrolled tile-map lookup, ROM addressing and pixel select
// with a 3-cycle pipeline that keeps RGB aligned with the delayed syncs.
module tile_renderer #(
    parameter int          H_ACTIVE  = 640,
    parameter int          H_TOTAL   = 800,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_TOTAL   = 525,
    parameter int          MAP_COLS  = 64,
    parameter int          MAP_ROWS  = 20,
    parameter logic [11:0] SKY_COLOR = 12'h6BF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [9:0]  scroll_x,
    input  logic        map_we,
    input  logic [5:0]  map_wcol,
    input  logic [4:0]  map_wrow,
    input  logic [1:0]  map_wtype,
    output logic [9:0]  rom_addr,
    input  logic [11:0] ground_pixel,
    input  logic [11:0] platform_pixel,
    output logic [11:0] rgb_out,
    output logic        hsync_out,
    output logic        vsync_out
);

    localparam int COL_W   = $clog2(MAP_COLS);
    localparam int IDX_W   = 5 + COL_W;
    localparam int MAP_N   = MAP_ROWS * MAP_COLS;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic [9:0] tile_addr(input logic [4:0] y, input logic [4:0] x);
        return {1'b0, y, 4'b0000} + {2'b00, y, 3'b000} + {5'b00000, x};
    endfunction

    function automatic logic [11:0] pick_pixel(input logic [1:0] t, input logic vld,
                                               input logic [11:0] g, input logic [11:0] p);
        if (!vld) return 12'h000;
        case (t)
            2'd1:    return g;
            2'd2:    return p;
            default: return SKY_COLOR;
        endcase
    endfunction

    logic [1:0]       state_q, state_d;
    logic [9:0]       rem_q, rem_d;
    logic [5:0]       quo_q, quo_d;
    logic [4:0]       px_q, px_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [4:0]       py_q, py_d;
    logic [4:0]       row_q, row_d;

    logic [1:0]       map_q [MAP_N];
    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [1:0]       tile_type;

    logic             line_end, line_start_div;

    logic [9:0]       rom_addr_q;
    logic [1:0]       type_p1_q, type_p2_q;
    logic             vld_p1_q, vld_p2_q;
    logic             hs_p1_q, hs_p2_q, vs_p1_q, vs_p2_q;
    logic [11:0]      rgb_q;
    logic             hs_q, vs_q;

    assign line_end       = (hcount == 10'(H_TOTAL - 1));
    assign line_start_div = (hcount == 10'(H_ACTIVE));

    // Scroll split into tile column and pixel offset by repeated subtraction in hblank
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        if (line_start_div) begin
            state_d = S_DIV;
            rem_d   = scroll_x;
            quo_d   = 6'd0;
        end else begin
            case (state_q)
                S_DIV: begin
                    if (rem_q >= 10'd24) begin
                        rem_d = rem_q - 10'd24;
                        quo_d = quo_q + 6'd1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (line_end) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        px_d  = px_q;
        col_d = col_q;
        if (line_end) begin
            px_d  = rem_q[4:0];
            col_d = COL_W'(quo_q);
        end else if (video_on) begin
            if (px_q == 5'd23) begin
                px_d  = 5'd0;
                col_d = col_q + COL_W'(1);
            end else begin
                px_d  = px_q + 5'd1;
            end
        end
    end

    always_comb begin
        py_d  = py_q;
        row_d = row_q;
        if (line_end) begin
            if (vcount == 10'(V_TOTAL - 1)) begin
                py_d  = 5'd0;
                row_d = 5'd0;
            end else if (vcount < 10'(V_ACTIVE)) begin
                if (py_q == 5'd23) begin
                    py_d  = 5'd0;
                    row_d = row_q + 5'd1;
                end else begin
                    py_d  = py_q + 5'd1;
                end
            end
        end
    end

    // Map read is combinational off the current registers, so a same-cycle write is not seen
    assign rd_idx    = {row_q, col_q};
    assign wr_idx    = {map_wrow, map_wcol[COL_W-1:0]};
    assign tile_type = (row_q < 5'(MAP_ROWS)) ? map_q[rd_idx] : 2'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAP_N; i++) map_q[i] <= 2'd0;
        end else if (map_we && (map_wrow < 5'(MAP_ROWS))) begin
            map_q[wr_idx] <= map_wtype;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= 10'd0;
            quo_q   <= 6'd0;
            px_q    <= 5'd0;
            col_q   <= '0;
            py_q    <= 5'd0;
            row_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            px_q    <= px_d;
            col_q   <= col_d;
            py_q    <= py_d;
            row_q   <= row_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr_q <= 10'd0;
            type_p1_q  <= 2'd0;
            vld_p1_q   <= 1'b0;
            hs_p1_q    <= 1'b0;
            vs_p1_q    <= 1'b0;
            type_p2_q  <= 2'd0;
            vld_p2_q   <= 1'b0;
            hs_p2_q    <= 1'b0;
            vs_p2_q    <= 1'b0;
            rgb_q      <= 12'h000;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
        end else begin
            // stage 1: ROM address, tile type and video flag
            rom_addr_q <= tile_addr(py_q, px_q);
            type_p1_q  <= tile_type;
            vld_p1_q   <= video_on;
            hs_p1_q    <= hsync_in;
            vs_p1_q    <= vsync_in;
            // stage 2: ROM data is being returned
            type_p2_q  <= type_p1_q;
            vld_p2_q   <= vld_p1_q;
            hs_p2_q    <= hs_p1_q;
            vs_p2_q    <= vs_p1_q;
            // stage 3: pixel select
            rgb_q      <= pick_pixel(type_p2_q, vld_p2_q, ground_pixel, platform_pixel);
            hs_q       <= hs_p2_q;
            vs_q       <= vs_p2_q;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign rgb_out   = rgb_q;
    assign hsync_out = hs_q;
    assign vsync_out = vs_q;

endmodule

// File: tb/tb_tile_renderer.sv
// Directed bench for tile_renderer: drives raster positions line by line against a
// 1-cycle ROM model and checks hand-computed addresses, colours and sync delays.
module tb_tile_renderer;

    localparam logic [11:0] SKY = 12'h6BF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  hcount = 10'd0;
    logic [9:0]  vcount = 10'd0;
    logic        video_on = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic [9:0]  scroll_x = 10'd0;
    logic        map_we = 1'b0;
    logic [5:0]  map_wcol = 6'd0;
    logic [4:0]  map_wrow = 5'd0;
    logic [1:0]  map_wtype = 2'd0;
    logic [9:0]  rom_addr;
    logic [11:0] ground_pixel = 12'h000;
    logic [11:0] platform_pixel = 12'h000;
    logic [11:0] rgb_out;
    logic        hsync_out;
    logic        vsync_out;

    int n_chk  = 0;
    int n_pass = 0;

    logic [9:0]  addr_log [800];
    logic [11:0] rgb_at   [800];
    logic [2:0]  hs_pipe = 3'b000;
    logic [2:0]  vs_pipe = 3'b000;

    tile_renderer dut (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .scroll_x(scroll_x),
        .map_we(map_we), .map_wcol(map_wcol), .map_wrow(map_wrow), .map_wtype(map_wtype),
        .rom_addr(rom_addr), .ground_pixel(ground_pixel), .platform_pixel(platform_pixel),
        .rgb_out(rgb_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #5 clk = ~clk;

    // ROM contents tag the source and echo the address so colours reveal both
    always @(posedge clk) begin
        ground_pixel   <= 12'h800 | {2'b00, rom_addr};
        platform_pixel <= 12'h400 | {2'b00, rom_addr};
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input int h, input int v);
        hcount   = 10'(h);
        vcount   = 10'(v);
        video_on = (h < 640) && (v < 480);
        hsync_in = (h >= 656) && (h < 752);
        vsync_in = (v >= 490) && (v < 492);
        @(posedge clk);
        #1;
        hs_pipe = {hs_pipe[1:0], hsync_in};
        vs_pipe = {vs_pipe[1:0], vsync_in};
        addr_log[h] = rom_addr;
        rgb_at[h]   = rgb_out;
        check_val("hsync_dly", {31'd0, hsync_out}, {31'd0, hs_pipe[2]});
        check_val("vsync_dly", {31'd0, vsync_out}, {31'd0, vs_pipe[2]});
        map_we = 1'b0;
    endtask

    task automatic map_write(input int c, input int r, input int t, input int h, input int v);
        map_we    = 1'b1;
        map_wcol  = 6'(c);
        map_wrow  = 5'(r);
        map_wtype = 2'(t);
        drive(h, v);
    endtask

    task automatic full_line(input int v);
        for (int h = 0; h < 800; h++) drive(h, v);
    endtask

    task automatic short_line(input int v);
        drive(640, v);
        repeat (50) drive(700, v);
        drive(799, v);
    endtask

    initial begin
        int nz;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_addr",  {22'd0, rom_addr}, 32'd0);
        check_val("rst_rgb",   {20'd0, rgb_out},  32'd0);
        check_val("rst_hsync", {31'd0, hsync_out}, 32'd0);
        check_val("rst_vsync", {31'd0, vsync_out}, 32'd0);
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        rst = 1'b0;

        map_write(2, 0, 1, 700, 524);
        map_write(3, 0, 2, 700, 524);
        map_write(42, 0, 1, 700, 524);
        scroll_x = 10'd50;
        full_line(524);

        for (int h = 0; h <= 300; h++) drive(h, 0);
        check_val("pre_rst_rgb", {20'd0, rgb_at[300]}, {20'd0, SKY});
        rst = 1'b1;
        #1;
        check_val("async_rst_rgb",  {20'd0, rgb_out},  32'd0);
        check_val("async_rst_addr", {22'd0, rom_addr}, 32'd0);
        hs_pipe = 3'b000;
        vs_pipe = 3'b000;
        drive(301, 0);
        rst = 1'b0;
        drive(302, 0);
        drive(303, 0);
        check_val("post_rst_addr0", {22'd0, addr_log[302]}, 32'd0);
        check_val("post_rst_addr1", {22'd0, addr_log[303]}, 32'd1);
        map_write(2, 0, 1, 304, 0);
        map_write(3, 0, 2, 305, 0);
        map_write(42, 0, 1, 306, 0);
        for (int h = 307; h < 800; h++) drive(h, 0);
        full_line(524);

        for (int h = 0; h < 800; h++) begin
            if (h == 100) scroll_x = 10'd1023;
            drive(h, 0);
        end
        check_val("s50_addr_h0",  {22'd0, addr_log[0]},  32'd2);
        check_val("s50_rgb_h0",   {20'd0, rgb_at[2]},    32'h802);
        check_val("s50_addr_h21", {22'd0, addr_log[21]}, 32'd23);
        check_val("s50_addr_h22", {22'd0, addr_log[22]}, 32'd0);
        check_val("s50_rgb_h21",  {20'd0, rgb_at[23]},   32'h817);
        check_val("s50_rgb_h22",  {20'd0, rgb_at[24]},   32'h400);
        check_val("s50_rgb_h46",  {20'd0, rgb_at[48]},   {20'd0, SKY});
        check_val("s50_hold_h130", {22'd0, addr_log[130]}, 32'd12);
        check_val("hblank_rgb",   {20'd0, rgb_at[702]},  32'd0);

        full_line(1);
        check_val("s1023_addr_h0", {22'd0, addr_log[0]}, 32'd39);
        check_val("s1023_rgb_h0",  {20'd0, rgb_at[2]},   32'h827);
        check_val("s1023_addr_h8", {22'd0, addr_log[8]}, 32'd47);
        check_val("s1023_addr_h9", {22'd0, addr_log[9]}, 32'd24);
        check_val("s1023_rgb_h9",  {20'd0, rgb_at[11]},  {20'd0, SKY});

        scroll_x = 10'd0;
        for (int v = 2; v < 72; v++) short_line(v);

        for (int h = 0; h < 800; h++) begin
            if (h == 120) map_write(5, 3, 1, h, 72);
            else drive(h, 72);
        end
        check_val("row3_addr_h120", {22'd0, addr_log[120]}, 32'd0);
        check_val("wr_same_cycle",  {20'd0, rgb_at[122]},  {20'd0, SKY});
        check_val("wr_next_read",   {20'd0, rgb_at[123]},  32'h801);

        for (int v = 480; v < 525; v++) begin
            full_line(v);
            nz = 0;
            for (int h = 0; h < 800; h++) if (rgb_at[h] != 12'h000) nz++;
            check_val("vblank_rgb", 32'(nz), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
